// File: rtl/digit_serial_add_sub_if.sv
// Digit-serial add/sub handshake bundle: master drives operand digits, slave returns result digits.
interface digit_serial_add_sub_if #(
  parameter int DIGIT_W = 1
);
  logic               in_valid;
  logic               sub;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               out_valid;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               carry_out;
  logic               overflow;

  modport master (
    output in_valid, sub, a, b,
    input  out_valid, out_digit, out_last, carry_out, overflow
  );

  modport slave (
    input  in_valid, sub, a, b,
    output out_valid, out_digit, out_last, carry_out, overflow
  );
endinterface

// File: rtl/digit_serial_add_sub.sv
// Serial two's-complement add/sub, LSB digit first, counter-framed words; 1-cycle latency.
// No backpressure: every in_valid digit is accepted and yields one result digit next cycle.
module digit_serial_add_sub #(
  parameter int DIGIT_W  = 1,
  parameter int N_DIGITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  digit_serial_add_sub_if.slave bus
);
  localparam int CNT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               carry;
  logic               mode_q;

  logic               first;
  logic               last;
  logic               mode_eff;
  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W-1:0] s;
  logic [DIGIT_W:0]   c;

  // The first digit of a word takes its mode and carry-in straight from the inputs.
  always_comb begin
    first    = (state == IDLE);
    last     = (cnt == LAST_CNT);
    mode_eff = first ? bus.sub : mode_q;
    b_eff    = bus.b ^ {DIGIT_W{mode_eff}};
    s        = '0;
    c        = '0;
    c[0]     = first ? bus.sub : carry;
    for (int i = 0; i < DIGIT_W; i++) begin
      s[i]   = bus.a[i] ^ b_eff[i] ^ c[i];
      c[i+1] = (bus.a[i] & b_eff[i]) | (c[i] & (bus.a[i] ^ b_eff[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      carry         <= 1'b0;
      mode_q        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_digit <= '0;
      bus.out_last  <= 1'b0;
      bus.carry_out <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.out_digit <= s;
        bus.out_last  <= last;
        bus.carry_out <= last & c[DIGIT_W];
        bus.overflow  <= last & (c[DIGIT_W] ^ c[DIGIT_W-1]);
        if (first) begin
          mode_q <= bus.sub;
        end
        // Carry is dropped at word end so a back-to-back word starts clean.
        if (last) begin
          state <= IDLE;
          cnt   <= '0;
          carry <= 1'b0;
        end else begin
          state <= BUSY;
          cnt   <= cnt + CNT_W'(1);
          carry <= c[DIGIT_W];
        end
      end else begin
        bus.out_digit <= '0;
        bus.out_last  <= 1'b0;
        bus.carry_out <= 1'b0;
        bus.overflow  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Bench for digit_serial_add_sub: word-level arithmetic model, per-cycle output compare, directed + random words.
module tb_digit_serial_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  digit_serial_add_sub_if #(.DIGIT_W(1)) if0 ();
  digit_serial_add_sub_if #(.DIGIT_W(4)) if1 ();

  digit_serial_add_sub #(.DIGIT_W(1), .N_DIGITS(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  digit_serial_add_sub #(.DIGIT_W(4), .N_DIGITS(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Expected output for the digit accepted at the most recent edge
  bit         p0 = 1'b0, p1 = 1'b0;
  logic       e0_dig, e0_last, e0_c, e0_o;
  logic [3:0] e1_dig;
  logic       e1_last, e1_c, e1_o;

  // Words reassembled from the DUT outputs
  logic [15:0] acc0 = '0, acc1 = '0, w0 = '0, w1 = '0;
  logic        c0 = 1'b0, o0 = 1'b0, c1 = 1'b0, o1 = 1'b0;
  int          pos0 = 0, pos1 = 0, n0 = 0, n1 = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // {overflow, carry_out, result} of a 16-bit two's-complement a+b or a-b
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] f;
    logic [15:0] bb;
    logic        ovf;
    bb  = s ? ~b : b;
    f   = {1'b0, a} + {1'b0, bb} + {16'd0, s};
    ovf = s ? ((a[15] != b[15]) && (f[15] != a[15]))
            : ((a[15] == b[15]) && (f[15] != a[15]));
    return {ovf, f[16], f[15:0]};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0_cycle",
            {27'd0, if0.out_valid, if0.out_last, if0.carry_out, if0.overflow, if0.out_digit},
            p0 ? {27'd0, 1'b1, e0_last, e0_c, e0_o, e0_dig} : 32'd0);
      check("dut1_cycle",
            {24'd0, if1.out_valid, if1.out_last, if1.carry_out, if1.overflow, if1.out_digit},
            p1 ? {24'd0, 1'b1, e1_last, e1_c, e1_o, e1_dig} : 32'd0);
      p0 = 1'b0;
      p1 = 1'b0;
      if (if0.out_valid) begin
        acc0[pos0[3:0]] = if0.out_digit[0];
        if (if0.out_last) begin
          w0 = acc0; c0 = if0.carry_out; o0 = if0.overflow; n0 = pos0 + 1; pos0 = 0;
        end else pos0++;
      end
      if (if1.out_valid) begin
        acc1[4*pos1[1:0] +: 4] = if1.out_digit;
        if (if1.out_last) begin
          w1 = acc1; c1 = if1.carry_out; o1 = if1.overflow; n1 = pos1 + 1; pos1 = 0;
        end else pos1++;
      end
      if (!rst) begin
        pos0 = 0;
        pos1 = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one word to dut0; optional idle gaps after digits ga/gb, optional reset at digit rst_at.
  task automatic word0(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input int ga, input int la, input int gb, input int lb, input int rst_at);
    logic [17:0] m;
    m = model(a, b, s);
    for (int i = 0; i < 16; i++) begin
      if (i == rst_at) begin
        rst = 1'b0;
        if0.in_valid = 1'b1; if0.a = 1'($urandom); if0.b = 1'($urandom); if0.sub = 1'($urandom);
        step();
        rst = 1'b1;
        if0.in_valid = 1'b0;
        return;
      end
      if0.in_valid = 1'b1;
      if0.a   = a[i];
      if0.b   = b[i];
      if0.sub = (i == 0) ? s : 1'($urandom);
      step();
      e0_dig = m[i]; e0_last = (i == 15);
      e0_c = (i == 15) & m[16]; e0_o = (i == 15) & m[17]; p0 = 1'b1;
      if0.in_valid = 1'b0; if0.a = 1'($urandom); if0.b = 1'($urandom); if0.sub = 1'($urandom);
      if (i == ga) repeat (la) step();
      if (i == gb) repeat (lb) step();
    end
  endtask

  task automatic word1(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [17:0] m;
    m = model(a, b, s);
    for (int i = 0; i < 4; i++) begin
      if1.in_valid = 1'b1;
      if1.a   = a[4*i +: 4];
      if1.b   = b[4*i +: 4];
      if1.sub = (i == 0) ? s : 1'($urandom);
      step();
      e1_dig = m[4*i +: 4]; e1_last = (i == 3);
      e1_c = (i == 3) & m[16]; e1_o = (i == 3) & m[17]; p1 = 1'b1;
      if1.in_valid = 1'b0;
    end
  endtask

  task automatic expect0(input string name, input logic [15:0] w, input logic c, input logic o);
    step();
    check(name, {14'd0, w0, c0, o0}, {14'd0, w, c, o});
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time (vectors %0d)", vectors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.in_valid = 1'b0; if0.sub = 1'b0; if0.a = '0; if0.b = '0;
    if1.in_valid = 1'b0; if1.sub = 1'b0; if1.a = '0; if1.b = '0;
    rst = 1'b0;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b1;
    step();

    word0(16'h0005, 16'h0003, 1'b0, -1, 0, -1, 0, -1);
    expect0("t1_add_5_3", 16'h0008, 1'b0, 1'b0);
    check("t1_out_cycles", n0, 16);

    word0(16'h0003, 16'h0005, 1'b1, -1, 0, -1, 0, -1);
    word0(16'h0005, 16'h0003, 1'b1, -1, 0, -1, 0, -1);
    expect0("t2_sub_5_3_b2b", 16'h0002, 1'b1, 1'b0);
    word0(16'h0003, 16'h0005, 1'b1, -1, 0, -1, 0, -1);
    expect0("t2_sub_3_5", 16'hFFFE, 1'b0, 1'b0);

    word0(16'h7FFF, 16'h0001, 1'b0, -1, 0, -1, 0, -1);
    expect0("t3_add_ovf", 16'h8000, 1'b0, 1'b1);
    word0(16'hFFFF, 16'h0001, 1'b0, -1, 0, -1, 0, -1);
    expect0("t3_add_carry", 16'h0000, 1'b1, 1'b0);
    word0(16'h8000, 16'h0001, 1'b1, -1, 0, -1, 0, -1);
    expect0("t3_sub_ovf", 16'h7FFF, 1'b1, 1'b1);

    word1(16'h1234, 16'h0FFF, 1'b0);
    step();
    check("t4_w4_add", {15'd0, w1, c1}, {15'd0, 16'h2233, 1'b0});
    check("t4_out_cycles", n1, 4);

    word0(16'h00FF, 16'h0101, 1'b0, 2, 2, 8, 3, -1);
    expect0("t5_gaps", 16'h0200, 1'b0, 1'b0);

    word0(16'hFFFF, 16'hFFFF, 1'b0, -1, 0, -1, 0, 6);
    word0(16'h0001, 16'h0001, 1'b0, -1, 0, -1, 0, -1);
    expect0("t6_after_rst", 16'h0002, 1'b0, 1'b0);

    for (int w = 0; w < 1000; w++) begin
      int ga, gb, ra;
      ga = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      gb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      ra = ($urandom_range(0, 49) == 0) ? int'($urandom_range(1, 15)) : -1;
      word0(16'($urandom), 16'($urandom), 1'($urandom),
            ga, int'($urandom_range(1, 3)), gb, int'($urandom_range(1, 3)), ra);
      if ($urandom_range(0, 3) == 0) step();
    end

    for (int w = 0; w < 200; w++) begin
      word1(16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) step();
    end

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
